keypad_scanner: RTL and testbench

// - Input-side counterpart of the multiplexed 7-segment display driver. Scans a 4x4 matrix keypad:

---
 rtl/keypad_pkg.sv | 30 +++
 rtl/key_sync.sv | 24 ++
 rtl/keypad_scanner.sv | 141 ++++++++++++++
 tb/tb_keypad_scanner.sv | 280 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/keypad_pkg.sv
// Shared types and constants for the 4x4 keypad scanner: FSM encoding, key map, debounce default.
package keypad_pkg;

  typedef enum logic [1:0] {
    SCAN     = 2'd0,
    DEBOUNCE = 2'd1,
    PRESSED  = 2'd2,
    RELEASE  = 2'd3
  } state_e;

  localparam int DEB_TICKS_DEFAULT = 4;

  // Nibble {row,col} holds the hex code; row 3 maps '*' to E and '#' to F.
  localparam logic [63:0] KEYMAP = 64'hDF0E_C987_B654_A321;

  function automatic logic [3:0] key_lookup(input logic [1:0] r, input logic [1:0] c);
    return KEYMAP[{r, c, 2'b00} +: 4];
  endfunction

  // Lowest-numbered row pulled low wins when several keys share a column.
  function automatic logic [1:0] lowest_zero(input logic [3:0] rows);
    logic [1:0] idx;
    idx = 2'd3;
    for (int i = 3; i >= 0; i--) begin
      if (!rows[i]) idx = 2'(i);
    end
    return idx;
  endfunction

endpackage

// File: rtl/key_sync.sv
// Two-flop synchronizer for the asynchronous keypad rows; 2 cycles latency, idles at all ones.
module key_sync (
  input  logic       clk,
  input  logic       rst,
  input  logic [3:0] row_i,
  output logic [3:0] rs_o
);

  logic [3:0] meta_q;
  logic [3:0] sync_q;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      meta_q <= 4'hF;
      sync_q <= 4'hF;
    end else begin
      meta_q <= row_i;
      sync_q <= meta_q;
    end
  end

  assign rs_o = sync_q;

endmodule

// File: rtl/keypad_scanner.sv
// Column-strobing 4x4 keypad scanner with press/release debounce and a 6-digit entry shift register.
// Decisions only on scan_f ticks; key_valid pulses one cycle after the accepting tick.
module keypad_scanner
  import keypad_pkg::*;
#(
  parameter int DEB_TICKS = DEB_TICKS_DEFAULT
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        scan_f,
  input  logic        clr,
  input  logic [3:0]  row_in,
  output logic [3:0]  col_out,
  output logic        key_valid,
  output logic [3:0]  key_code,
  output logic        key_held,
  output logic [23:0] hex
);

  localparam logic [4:0] DEB_LIMIT = 5'(DEB_TICKS);

  logic [3:0]  rs;
  state_e      state_q,     state_d;
  logic [1:0]  col_idx_q,   col_idx_d;
  logic [1:0]  row_q,       row_d;
  logic [3:0]  deb_cnt_q,   deb_cnt_d;
  logic        key_valid_q, key_valid_d;
  logic [3:0]  key_code_q,  key_code_d;
  logic        key_held_q,  key_held_d;
  logic [23:0] hex_q,       hex_d;
  logic        accept;
  logic [4:0]  deb_inc;
  logic        row_hi;

  key_sync u_sync (
    .clk   (clk),
    .rst   (rst),
    .row_i (row_in),
    .rs_o  (rs)
  );

  assign deb_inc = {1'b0, deb_cnt_q} + 5'd1;
  assign row_hi  = rs[row_q];

  always_comb begin
    state_d    = state_q;
    col_idx_d  = col_idx_q;
    row_d      = row_q;
    deb_cnt_d  = deb_cnt_q;
    key_held_d = key_held_q;
    key_code_d = key_code_q;
    accept     = 1'b0;

    if (scan_f) begin
      unique case (state_q)
        SCAN: begin
          if (rs == 4'hF) begin
            col_idx_d = col_idx_q + 2'd1;
          end else begin
            row_d     = lowest_zero(rs);
            deb_cnt_d = 4'd1;
            state_d   = DEBOUNCE;
          end
        end
        DEBOUNCE: begin
          if (!row_hi) begin
            deb_cnt_d = deb_inc[3:0];
            if (deb_inc >= DEB_LIMIT) begin
              accept     = 1'b1;
              key_held_d = 1'b1;
              key_code_d = key_lookup(row_q, col_idx_q);
              state_d    = PRESSED;
            end
          end else begin
            // Bounce: rescan the same column rather than skipping past the key.
            state_d = SCAN;
          end
        end
        PRESSED: begin
          if (row_hi) begin
            deb_cnt_d = 4'd1;
            state_d   = RELEASE;
          end
        end
        RELEASE: begin
          if (row_hi) begin
            deb_cnt_d = deb_inc[3:0];
            if (deb_inc >= DEB_LIMIT) begin
              key_held_d = 1'b0;
              col_idx_d  = col_idx_q + 2'd1;
              state_d    = SCAN;
            end
          end else begin
            state_d = PRESSED;
          end
        end
        default: state_d = SCAN;
      endcase
    end

    key_valid_d = accept;

    // Clear wins over a same-cycle accept; the code still lands in key_code.
    if (clr) begin
      hex_d = 24'h0;
    end else if (accept) begin
      hex_d = {hex_q[19:0], key_code_d};
    end else begin
      hex_d = hex_q;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= SCAN;
      col_idx_q   <= 2'd0;
      row_q       <= 2'd0;
      deb_cnt_q   <= 4'd0;
      key_valid_q <= 1'b0;
      key_code_q  <= 4'd0;
      key_held_q  <= 1'b0;
      hex_q       <= 24'h0;
    end else begin
      state_q     <= state_d;
      col_idx_q   <= col_idx_d;
      row_q       <= row_d;
      deb_cnt_q   <= deb_cnt_d;
      key_valid_q <= key_valid_d;
      key_code_q  <= key_code_d;
      key_held_q  <= key_held_d;
      hex_q       <= hex_d;
    end
  end

  assign col_out   = ~(4'b0001 << col_idx_q);
  assign key_valid = key_valid_q;
  assign key_code  = key_code_q;
  assign key_held  = key_held_q;
  assign hex       = hex_q;

endmodule

// File: tb/tb_keypad_scanner.sv
// Bench for keypad_scanner: a keypad model drives rows from col_out; accepted keys are scoreboarded.
module tb_keypad_scanner;

  localparam int DEB = 4;

  typedef struct packed {
    logic [3:0]  code;
    logic [23:0] hexv;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        scan_f = 1'b0;
  logic        clr_man = 1'b0;
  logic        clr_on_tick = 1'b0;
  logic        clr;
  logic [3:0]  row_in;
  logic [3:0]  col_out;
  logic        key_valid;
  logic [3:0]  key_code;
  logic        key_held;
  logic [23:0] hex;

  logic [15:0] pressed = '0;
  logic [3:0]  kmap [16] = '{4'h1, 4'h2, 4'h3, 4'hA,
                             4'h4, 4'h5, 4'h6, 4'hB,
                             4'h7, 4'h8, 4'h9, 4'hC,
                             4'hE, 4'h0, 4'hF, 4'hD};
  exp_t        exp_q [$];
  logic [23:0] hex_model = '0;
  int          tick_cnt = 0;
  int          pulse_cnt = 0;
  int          run_len = 0;
  int          n_vec = 0;
  int          n_err = 0;

  keypad_scanner #(.DEB_TICKS(DEB)) dut (
    .clk       (clk),
    .rst       (rst),
    .scan_f    (scan_f),
    .clr       (clr),
    .row_in    (row_in),
    .col_out   (col_out),
    .key_valid (key_valid),
    .key_code  (key_code),
    .key_held  (key_held),
    .hex       (hex)
  );

  always #5 clk = ~clk;

  assign clr = clr_man | (clr_on_tick & scan_f);

  // Keypad matrix: a pressed key shorts its row to its column when that column is driven low.
  always_comb begin
    row_in = 4'hF;
    for (int r = 0; r < 4; r++)
      for (int c = 0; c < 4; c++)
        if (pressed[r*4+c] && !col_out[c]) row_in[r] = 1'b0;
  end

  initial begin
    forever begin
      repeat (7) @(negedge clk);
      scan_f = 1'b1;
      @(negedge clk);
      scan_f = 1'b0;
      tick_cnt++;
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    n_vec++;
    if (obs !== expv) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", tag, obs, expv, $time);
    end
  endtask

  always @(negedge clk) begin
    if (rst && key_valid) begin
      pulse_cnt++;
      run_len++;
      if (exp_q.size() == 0) begin
        chk("unexpected_pulse", exp_q.size(), 1);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        chk("sb_code", {28'd0, key_code}, {28'd0, e.code});
        chk("sb_hex", {8'd0, hex}, {8'd0, e.hexv});
      end
    end else if (run_len != 0) begin
      chk("pulse_width", run_len, 1);
      run_len = 0;
    end
  end

  task automatic wait_ticks(input int n);
    int target;
    target = tick_cnt + n;
    while (tick_cnt < target) @(negedge clk);
  endtask

  task automatic wait_held(input logic val, input string tag);
    int n;
    n = 0;
    while (key_held !== val && n < 400) begin
      @(negedge clk);
      n++;
    end
    if (key_held !== val) chk(tag, {31'd0, key_held}, {31'd0, val});
  endtask

  task automatic wait_col(input int c, input string tag);
    logic [3:0] want;
    int n;
    want = ~(4'b0001 << c);
    n = 0;
    while (col_out !== want && n < 400) begin
      @(negedge clk);
      n++;
    end
    if (col_out !== want) chk(tag, {28'd0, col_out}, {28'd0, want});
  endtask

  task automatic expect_key(input int r, input int c, input logic shift);
    exp_t e;
    e.code = kmap[r*4+c];
    if (shift) hex_model = {hex_model[19:0], e.code};
    e.hexv = hex_model;
    exp_q.push_back(e);
  endtask

  task automatic press_release(input int r, input int c, input int hold);
    expect_key(r, c, 1'b1);
    pressed[r*4+c] = 1'b1;
    wait_held(1'b1, "held_rise_timeout");
    wait_ticks(hold);
    pressed[r*4+c] = 1'b0;
    wait_held(1'b0, "held_fall_timeout");
  endtask

  initial begin
    int p0;
    int n;
    logic [3:0] want;

    // Reset values
    repeat (3) @(negedge clk);
    chk("rst_col", {28'd0, col_out}, 32'hE);
    chk("rst_valid", {31'd0, key_valid}, 32'd0);
    chk("rst_code", {28'd0, key_code}, 32'd0);
    chk("rst_held", {31'd0, key_held}, 32'd0);
    chk("rst_hex", {8'd0, hex}, 32'd0);
    rst = 1'b1;

    // Key 5 held on col1 for 2*DEB ticks
    wait_col(1, "col1_timeout");
    p0 = pulse_cnt;
    expect_key(1, 1, 1'b1);
    pressed[5] = 1'b1;
    wait_ticks(2 * DEB);
    chk("k5_pulses", pulse_cnt, p0 + 1);
    chk("k5_held", {31'd0, key_held}, 32'd1);
    chk("k5_code", {28'd0, key_code}, 32'h5);
    chk("k5_hex", {8'd0, hex}, 32'h000005);
    pressed[5] = 1'b0;
    wait_held(1'b0, "k5_release_timeout");

    // Bounce shorter than the debounce window
    wait_col(2, "col2_timeout");
    p0 = pulse_cnt;
    pressed[2] = 1'b1;
    wait_ticks(DEB - 1);
    pressed[2] = 1'b0;
    wait_ticks(1);
    chk("bounce_col", {28'd0, col_out}, 32'hB);
    chk("bounce_held", {31'd0, key_held}, 32'd0);
    wait_ticks(3);
    chk("bounce_pulses", pulse_cnt, p0);

    // Clear, then keys 1 2 3, then four more to push the oldest out
    clr_man = 1'b1;
    @(negedge clk);
    clr_man = 1'b0;
    hex_model = '0;
    chk("clr_hex", {8'd0, hex}, 32'd0);
    p0 = pulse_cnt;
    press_release(0, 0, 2);
    press_release(0, 1, 2);
    press_release(0, 2, 2);
    chk("k123_pulses", pulse_cnt, p0 + 3);
    chk("k123_hex", {8'd0, hex}, 32'h000123);
    press_release(1, 0, 1);
    press_release(1, 1, 1);
    press_release(1, 2, 1);
    press_release(2, 0, 1);
    chk("seven_hex", {8'd0, hex}, 32'h234567);

    // Key 8 held for 50 ticks, then release timing
    p0 = pulse_cnt;
    expect_key(2, 1, 1'b1);
    pressed[9] = 1'b1;
    wait_held(1'b1, "k8_held_timeout");
    wait_ticks(50);
    chk("k8_one_pulse", pulse_cnt, p0 + 1);
    chk("k8_held_long", {31'd0, key_held}, 32'd1);
    pressed[9] = 1'b0;
    wait_ticks(DEB - 1);
    chk("k8_held_before", {31'd0, key_held}, 32'd1);
    wait_ticks(1);
    chk("k8_released", {31'd0, key_held}, 32'd0);

    // Rows 0 and 2 on col0: lowest row wins
    expect_key(0, 0, 1'b1);
    pressed[0] = 1'b1;
    pressed[8] = 1'b1;
    wait_held(1'b1, "multi_timeout");
    chk("multi_code", {28'd0, key_code}, 32'h1);
    wait_ticks(2);
    pressed[0] = 1'b0;
    pressed[8] = 1'b0;
    wait_held(1'b0, "multi_release_timeout");

    // clr coincident with accept (clr asserted on every tick)
    clr_on_tick = 1'b1;
    hex_model = '0;
    expect_key(2, 2, 1'b0);
    pressed[10] = 1'b1;
    n = 0;
    while (!key_valid && n < 400) begin
      @(negedge clk);
      n++;
    end
    chk("clracc_valid", {31'd0, key_valid}, 32'd1);
    chk("clracc_hex", {8'd0, hex}, 32'd0);
    chk("clracc_code", {28'd0, key_code}, 32'h9);
    clr_on_tick = 1'b0;
    wait_ticks(1);
    pressed[10] = 1'b0;
    wait_held(1'b0, "clracc_release_timeout");

    // Reset during DEBOUNCE
    wait_col(3, "col3_timeout");
    p0 = pulse_cnt;
    pressed[15] = 1'b1;
    wait_ticks(2);
    rst = 1'b0;
    #1;
    chk("mrst_col", {28'd0, col_out}, 32'hE);
    chk("mrst_held", {31'd0, key_held}, 32'd0);
    chk("mrst_valid", {31'd0, key_valid}, 32'd0);
    chk("mrst_code", {28'd0, key_code}, 32'd0);
    chk("mrst_hex", {8'd0, hex}, 32'd0);
    pressed[15] = 1'b0;
    hex_model = '0;
    repeat (3) @(negedge clk);
    rst = 1'b1;

    // Column rotation after reset release
    for (int k = 1; k <= 8; k++) begin
      wait_ticks(1);
      want = ~(4'b0001 << (k % 4));
      chk("rot_col", {28'd0, col_out}, {28'd0, want});
      chk("rot_onehot", $countones(~col_out), 1);
    end
    chk("mrst_no_pulse", pulse_cnt, p0);
    chk("sb_drained", exp_q.size(), 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #2ms;
    $display("FAIL watchdog: simulation did not complete, got timeout, expected completion");
    $fatal(1, "watchdog");
  end

endmodule
